// File: rtl/markov_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : markov_pkg
//  Brief    : Shared types and default widths for the Markov table blocks
//             (accumulator, list merge, table store).
//  Revision : 1.0  initial release
// ============================================================================
package markov_pkg;

    localparam int KEY_W_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = 16;
    localparam int DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MERGE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/markov_count_add.sv
`default_nettype none
// ============================================================================
//  Module   : markov_count_add
//  Brief    : Count adder with carry flag; result saturates to all-ones or
//             wraps depending on SATURATE. Shared with the accumulator.
//  Revision : 1.0  initial release
// ============================================================================
module markov_count_add #(
    parameter int CNT_W    = 16,
    parameter int SATURATE = 1
) (
    input  logic [CNT_W-1:0] a,
    input  logic [CNT_W-1:0] b,
    output logic [CNT_W-1:0] sum,
    output logic             carry
);

    logic [CNT_W:0] w_full;

    // Add one bit wider so the carry out is visible, then clamp or wrap.
    always_comb begin
        w_full = {1'b0, a} + {1'b0, b};
        carry  = w_full[CNT_W];
        if (carry && (SATURATE != 0)) begin
            sum = '1;
        end else begin
            sum = w_full[CNT_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/markov_list_merge.sv
`default_nettype none
// ============================================================================
//  Module   : markov_list_merge
//  Brief    : Merges two key-sorted (key, count) lists into one sorted output
//             list, one entry per cycle; equal keys are emitted once with
//             their counts summed.
//  Revision : 1.0  initial release
// ============================================================================
module markov_list_merge
    import markov_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len_a,
    input  logic [ADDR_W:0]   len_b,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [KEY_W-1:0]  a_key,
    input  logic [KEY_W-1:0]  b_key,
    input  logic [CNT_W-1:0]  a_cnt,
    input  logic [CNT_W-1:0]  b_cnt,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [KEY_W-1:0]  out_key,
    output logic [CNT_W-1:0]  out_cnt,
    output logic [ADDR_W:0]   out_len,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              sat_event
);

    localparam int              LEN_W       = ADDR_W + 1;
    localparam logic [LEN_W-1:0] c_depth_len = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] c_one       = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] i_q, i_d;
    logic [LEN_W-1:0] j_q, j_d;
    logic [LEN_W-1:0] len_a_q, len_a_d;
    logic [LEN_W-1:0] len_b_q, len_b_d;
    logic [LEN_W-1:0] out_len_q, out_len_d;
    logic             overflow_q, overflow_d;
    logic             sat_q, sat_d;

    logic             w_a_rem;
    logic             w_b_rem;
    logic             w_take_a;
    logic             w_take_b;
    logic [CNT_W-1:0] w_sum;
    logic             w_carry;
    logic             w_we;
    logic [KEY_W-1:0] w_key;
    logic [CNT_W-1:0] w_cnt;

    markov_count_add #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
    ) u_count_add (
        .a     (a_cnt),
        .b     (b_cnt),
        .sum   (w_sum),
        .carry (w_carry)
    );

    // Which list supplies the next entry; equal keys fall through to the sum path.
    always_comb begin
        w_a_rem  = (i_q < len_a_q);
        w_b_rem  = (j_q < len_b_q);
        w_take_a = w_a_rem && (!w_b_rem || (a_key < b_key));
        w_take_b = w_b_rem && (!w_a_rem || (b_key < a_key));
    end

    // Next-state, index updates and write-port data.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        len_a_d    = len_a_q;
        len_b_d    = len_b_q;
        out_len_d  = out_len_q;
        overflow_d = overflow_q;
        sat_d      = sat_q;
        w_we       = 1'b0;
        w_key      = '0;
        w_cnt      = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    len_a_d    = (len_a > c_depth_len) ? c_depth_len : len_a;
                    len_b_d    = (len_b > c_depth_len) ? c_depth_len : len_b;
                    i_d        = '0;
                    j_d        = '0;
                    out_len_d  = '0;
                    overflow_d = 1'b0;
                    sat_d      = 1'b0;
                    state_d    = ST_MERGE;
                end
            end
            ST_MERGE: begin
                if (!w_a_rem && !w_b_rem) begin
                    state_d = ST_DONE;
                end else if (out_len_q == c_depth_len) begin
                    // An entry is still pending but the output list is full.
                    overflow_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    w_we      = 1'b1;
                    out_len_d = out_len_q + c_one;
                    if (w_take_a) begin
                        w_key = a_key;
                        w_cnt = a_cnt;
                        i_d   = i_q + c_one;
                    end else if (w_take_b) begin
                        w_key = b_key;
                        w_cnt = b_cnt;
                        j_d   = j_q + c_one;
                    end else begin
                        w_key = a_key;
                        w_cnt = w_sum;
                        i_d   = i_q + c_one;
                        j_d   = j_q + c_one;
                        if (w_carry) begin
                            sat_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            len_a_q    <= '0;
            len_b_q    <= '0;
            out_len_q  <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            len_a_q    <= len_a_d;
            len_b_q    <= len_b_d;
            out_len_q  <= out_len_d;
            overflow_q <= overflow_d;
            sat_q      <= sat_d;
        end
    end

    // Write port is suppressed while reset is held so a mid-merge reset
    // cannot corrupt the table store before the state register clears.
    always_comb begin
        out_we    = w_we & reset;
        out_addr  = out_we ? out_len_q[ADDR_W-1:0] : '0;
        out_key   = out_we ? w_key : '0;
        out_cnt   = out_we ? w_cnt : '0;
        a_addr    = i_q[ADDR_W-1:0];
        b_addr    = j_q[ADDR_W-1:0];
        out_len   = out_len_q;
        busy      = (state_q == ST_MERGE);
        done      = (state_q == ST_DONE);
        overflow  = overflow_q;
        sat_event = sat_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_markov_list_merge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_markov_list_merge
//  Brief    : Scoreboard bench for markov_list_merge. Three instances share
//             the list memories and control: default widths, a small
//             saturating one and a small wrapping one.
//  Revision : 1.0  initial release
// ============================================================================
module tb_markov_list_merge;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  key;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [4:0] len_a = '0;
    logic [4:0] len_b = '0;
    int sel = 0;

    logic [7:0]  mem_a_key [16];
    logic [15:0] mem_a_cnt [16];
    logic [7:0]  mem_b_key [16];
    logic [15:0] mem_b_cnt [16];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   wr_cnt   = 0;
    int   exp_n;
    bit   exp_ovf, exp_sat;

    always #5 clk = ~clk;

    // ---------------- instance 0: KEY 8, CNT 16, DEPTH 16 ----------------
    logic [3:0]  a_addr0, b_addr0, out_addr0;
    logic [15:0] out_cnt0;
    logic [7:0]  out_key0;
    logic [4:0]  out_len0;
    logic        we0, busy0, done0, ovf0, sat0;

    markov_list_merge #(.KEY_W(8), .CNT_W(16), .DEPTH(16), .SATURATE(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .len_a(len_a), .len_b(len_b),
        .a_addr(a_addr0), .b_addr(b_addr0),
        .a_key(mem_a_key[a_addr0]), .b_key(mem_b_key[b_addr0]),
        .a_cnt(mem_a_cnt[a_addr0]), .b_cnt(mem_b_cnt[b_addr0]),
        .out_we(we0), .out_addr(out_addr0), .out_key(out_key0), .out_cnt(out_cnt0),
        .out_len(out_len0), .busy(busy0), .done(done0), .overflow(ovf0), .sat_event(sat0)
    );

    // ---------------- instances 1/2: CNT 4, DEPTH 4 ----------------
    logic [1:0] a_addr1, b_addr1, out_addr1, a_addr2, b_addr2, out_addr2;
    logic [3:0] out_cnt1, out_cnt2;
    logic [7:0] out_key1, out_key2;
    logic [2:0] out_len1, out_len2;
    logic       we1, busy1, done1, ovf1, sat1;
    logic       we2, busy2, done2, ovf2, sat2;

    markov_list_merge #(.KEY_W(8), .CNT_W(4), .DEPTH(4), .SATURATE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .len_a(len_a[2:0]), .len_b(len_b[2:0]),
        .a_addr(a_addr1), .b_addr(b_addr1),
        .a_key(mem_a_key[{2'b00, a_addr1}]), .b_key(mem_b_key[{2'b00, b_addr1}]),
        .a_cnt(mem_a_cnt[{2'b00, a_addr1}][3:0]), .b_cnt(mem_b_cnt[{2'b00, b_addr1}][3:0]),
        .out_we(we1), .out_addr(out_addr1), .out_key(out_key1), .out_cnt(out_cnt1),
        .out_len(out_len1), .busy(busy1), .done(done1), .overflow(ovf1), .sat_event(sat1)
    );

    markov_list_merge #(.KEY_W(8), .CNT_W(4), .DEPTH(4), .SATURATE(0)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .len_a(len_a[2:0]), .len_b(len_b[2:0]),
        .a_addr(a_addr2), .b_addr(b_addr2),
        .a_key(mem_a_key[{2'b00, a_addr2}]), .b_key(mem_b_key[{2'b00, b_addr2}]),
        .a_cnt(mem_a_cnt[{2'b00, a_addr2}][3:0]), .b_cnt(mem_b_cnt[{2'b00, b_addr2}][3:0]),
        .out_we(we2), .out_addr(out_addr2), .out_key(out_key2), .out_cnt(out_cnt2),
        .out_len(out_len2), .busy(busy2), .done(done2), .overflow(ovf2), .sat_event(sat2)
    );

    // Observed signals of the instance under test.
    logic        we_s, busy_s, done_s, ovf_s, sat_s;
    logic [7:0]  addr_s, key_s, len_s;
    logic [15:0] cnt_s;

    always_comb begin
        we_s = we0; busy_s = busy0; done_s = done0; ovf_s = ovf0; sat_s = sat0;
        addr_s = 8'(out_addr0); key_s = out_key0; cnt_s = out_cnt0; len_s = 8'(out_len0);
        if (sel == 1) begin
            we_s = we1; busy_s = busy1; done_s = done1; ovf_s = ovf1; sat_s = sat1;
            addr_s = 8'(out_addr1); key_s = out_key1; cnt_s = 16'(out_cnt1); len_s = 8'(out_len1);
        end else if (sel == 2) begin
            we_s = we2; busy_s = busy2; done_s = done2; ovf_s = ovf2; sat_s = sat2;
            addr_s = 8'(out_addr2); key_s = out_key2; cnt_s = 16'(out_cnt2); len_s = 8'(out_len2);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write of the selected instance must match the head.
    always @(negedge clk) begin
        if (we_s === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_we_addr", 32'(addr_s), 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("wr_addr", 32'(addr_s), 32'(e.addr));
                check_eq("wr_key",  32'(key_s),  32'(e.key));
                check_eq("wr_cnt",  32'(cnt_s),  32'(e.cnt));
            end
        end
    end

    task automatic put_a(input int idx, input int key, input int cnt);
        mem_a_key[idx] = 8'(key);
        mem_a_cnt[idx] = 16'(cnt);
    endtask

    task automatic put_b(input int idx, input int key, input int cnt);
        mem_b_key[idx] = 8'(key);
        mem_b_cnt[idx] = 16'(cnt);
    endtask

    // Reference merge: pushes expected writes, sets exp_n / exp_ovf / exp_sat.
    task automatic model(input int s, input int la_in, input int lb_in);
        int depth, mx, la, lb, i, j, ka, kb, ca, cb, sum;
        exp_t e;
        depth = (s == 0) ? 16 : 4;
        mx    = (s == 0) ? 65535 : 15;
        la = (la_in > depth) ? depth : la_in;
        lb = (lb_in > depth) ? depth : lb_in;
        i = 0; j = 0; exp_n = 0; exp_ovf = 0; exp_sat = 0;
        for (int k = 0; k < 40; k++) begin
            if (i == la && j == lb) break;
            if (exp_n == depth) begin
                exp_ovf = 1;
                break;
            end
            ka = (i < la) ? int'(mem_a_key[i]) : 0;
            ca = (i < la) ? (int'(mem_a_cnt[i]) & mx) : 0;
            kb = (j < lb) ? int'(mem_b_key[j]) : 0;
            cb = (j < lb) ? (int'(mem_b_cnt[j]) & mx) : 0;
            e.addr = 8'(exp_n);
            if (i < la && (j >= lb || ka < kb)) begin
                e.key = 8'(ka); e.cnt = 16'(ca); i++;
            end else if (j < lb && (i >= la || kb < ka)) begin
                e.key = 8'(kb); e.cnt = 16'(cb); j++;
            end else begin
                sum = ca + cb;
                if (sum > mx) begin
                    exp_sat = 1;
                    sum = (s == 2) ? (sum & mx) : mx;
                end
                e.key = 8'(ka); e.cnt = 16'(sum); i++; j++;
            end
            exp_q.push_back(e);
            exp_n++;
        end
    endtask

    // One full merge on instance s; done must appear at cycle N+2.
    task automatic run_merge(input int s, input int la, input int lb, input bit hold);
        int c;
        bit seen;
        model(s, la, lb);
        @(negedge clk);
        sel = s; len_a = 5'(la); len_b = 5'(lb); start = 1'b1; wr_cnt = 0;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        c = 0; seen = 0;
        while (c < 64 && !seen) begin
            @(negedge clk);
            c++;
            if (c == 1) check_eq("busy_c1", 32'(busy_s), 32'd1);
            if (done_s) seen = 1;
        end
        start = 1'b0;
        check_eq("done_cycle", 32'(c), 32'(exp_n + 2));
        check_eq("out_len",    32'(len_s), 32'(exp_n));
        check_eq("overflow",   32'(ovf_s), 32'(exp_ovf));
        check_eq("sat_event",  32'(sat_s), 32'(exp_sat));
        check_eq("n_writes",   32'(wr_cnt), 32'(exp_n));
        check_eq("sb_left",    32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic load_basic();
        put_a(0, 1, 3); put_a(1, 4, 2);
        put_b(0, 2, 5); put_b(1, 4, 7);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            put_a(k, 0, 0);
            put_b(k, 0, 0);
        end

        // Reset with start held: must stay idle with all outputs low.
        reset = 1'b0; start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy",    32'(busy0), 32'd0);
        check_eq("rst_done",    32'(done0), 32'd0);
        check_eq("rst_we",      32'(we0), 32'd0);
        check_eq("rst_len",     32'(out_len0), 32'd0);
        check_eq("rst_ovf",     32'(ovf0), 32'd0);
        check_eq("rst_sat",     32'(sat0), 32'd0);
        check_eq("rst_a_addr",  32'(a_addr0), 32'd0);
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic merge.
        load_basic();
        run_merge(0, 2, 2, 1'b0);

        // Both lists empty.
        run_merge(0, 0, 0, 1'b0);

        // Summed count overflows 4 bits: saturate, then wrap.
        put_a(0, 7, 12); put_b(0, 7, 9);
        run_merge(1, 1, 1, 1'b0);
        run_merge(2, 1, 1, 1'b0);

        // Output list overflow with DEPTH 4.
        put_a(0, 1, 1); put_a(1, 3, 1); put_a(2, 5, 1);
        put_b(0, 2, 1); put_b(1, 4, 1); put_b(2, 6, 1);
        run_merge(1, 3, 3, 1'b0);

        // Length clamp: len_a beyond DEPTH.
        put_a(0, 1, 2); put_a(1, 2, 3); put_a(2, 3, 4); put_a(3, 4, 5);
        run_merge(1, 5, 0, 1'b0);

        // Start held for the whole merge is ignored while merging.
        load_basic();
        run_merge(0, 2, 2, 1'b1);

        // Reset during cycle 2 of the basic merge: only the first write lands.
        model(0, 2, 2);
        @(negedge clk);
        sel = 0; len_a = 5'd2; len_b = 5'd2; start = 1'b1; wr_cnt = 0;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_we", 32'(we0), 32'd0);
        @(negedge clk);
        check_eq("midrst_busy", 32'(busy0), 32'd0);
        check_eq("midrst_done", 32'(done0), 32'd0);
        check_eq("midrst_len",  32'(out_len0), 32'd0);
        check_eq("midrst_key",  32'(out_key0), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_nwr",  32'(wr_cnt), 32'd1);
        check_eq("midrst_left", 32'(exp_q.size()), 32'd2);
        exp_q.delete();

        // Restart reproduces the full basic result.
        run_merge(0, 2, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/markov_list_merge.md
# markov_list_merge

Parametrised merge engine for Markov transition-count tables. It reads two key-sorted lists of (key, count) entries, A and B, each through a combinational read port. It writes their union to an output list memory in ascending key order, and entries with equal keys are emitted once with their counts summed. It sits between the per-symbol count accumulators and the table store, and replaces the fixed-size copy/merge/increment sequence with a single one-entry-per-cycle merge that is configurable in width and depth.

## Interface
- KEY_W, 8, key (next-symbol) width
- CNT_W, 16, count width
- DEPTH, 16, max entries per list (A, B and output)
- ADDR_W, $clog2(DEPTH), entry address width
- SATURATE, 1, 1 = counts saturate at 2^CNT_W-1; 0 = counts wrap modulo 2^CNT_W
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low; sampled on rising clk
- start  input  1  begin a merge; sampled only in IDLE or DONE
- len_a, len_b  input  ADDR_W+1  list lengths, sampled when start is accepted
- a_addr, b_addr  output  ADDR_W  read addresses
- a_key, b_key  input  KEY_W  read data, valid combinationally in the same cycle
- a_cnt, b_cnt  input  CNT_W  read data, valid combinationally in the same cycle
- out_we  output  1  write strobe
- out_addr  output  ADDR_W  write address
- out_key  output  KEY_W  write data
- out_cnt  output  CNT_W  write data
- out_len  output  ADDR_W+1  entries written in the current or last merge
- busy  output  1  high in MERGE
- done  output  1  high in DONE
- overflow  output  1  result did not fit in DEPTH entries
- sat_event  output  1  at least one summed count saturated or wrapped

## Operation
- The FSM has three states: IDLE, MERGE and DONE.
- Reset:
  - State goes to IDLE.
  - Indices i, j and out_len are cleared to 0.
  - All outputs are 0.
- IDLE/DONE with start=1:
  - Latch min(len_a, DEPTH) and min(len_b, DEPTH).
  - Clear i, j, out_len, overflow and sat_event.
  - Go to MERGE.
- start is ignored while in MERGE.
- a_addr = i and b_addr = j at all times.
- MERGE evaluates one case per cycle:
  - Both lists exhausted (i = len_a and j = len_b): out_we = 0, go to DONE.
  - out_len = DEPTH and an entry is pending: out_we = 0, set overflow, go to DONE.
  - Only A remains, or a_key < b_key: write (a_key, a_cnt), i++.
  - Only B remains, or b_key < a_key: write (b_key, b_cnt), j++.
  - a_key == b_key: write (a_key, a_cnt + b_cnt), i++ and j++.
- Every write drives out_addr = out_len, then out_len increments.
- Summation is done in CNT_W+1 bits:
  - If the carry is set: result is all-ones when SATURATE=1, or the low CNT_W bits when SATURATE=0.
  - Either way, sat_event sets sticky for the rest of the merge.
- DONE holds done=1. out_len, overflow and sat_event stay stable until the next accepted start.
- Input lists must be strictly ascending within each list. Behaviour on unsorted input is undefined, but the engine still terminates after at most len_a+len_b+1 MERGE cycles.

## Timing
- The start-accept edge is cycle 0. MERGE runs from cycle 1 and performs at most one write per cycle.
- A merge producing N entries without overflow:
  - N write cycles, then one terminating cycle.
  - done rises at cycle N+2.
- An overflowed merge: done rises at cycle DEPTH+2.
- out_we, out_addr, out_key and out_cnt are combinational from state, indices and read data, so the memory captures on the same edge.
- Reset asserted mid-merge returns to IDLE on the next edge. No further writes occur, and outputs read 0.
- start asserted on the same cycle as reset low is ignored.

## Structure
- Shared package markov_pkg holds:
  - the state enum (IDLE, MERGE, DONE)
  - the default KEY_W, CNT_W and DEPTH constants, shared with the accumulator and table-store blocks
- Sub-module markov_count_add:
  - parametrised CNT_W and SATURATE
  - combinational sum plus a carry/saturated flag
  - also reused by the accumulator

## Test plan
- Basic merge:
  - A = {1:3, 4:2}, B = {2:5, 4:7} -> outputs {1:3, 2:5, 4:9} at addrs 0..2.
  - out_len = 3, done at cycle 5, sat_event = 0.
- Both lists empty: len_a = len_b = 0 -> no out_we, done at cycle 2, out_len = 0.
- Count arithmetic, with CNT_W = 4 and A = {7:12}, B = {7:9}:
  - SATURATE = 1 -> out_cnt = 15.
  - SATURATE = 0 -> out_cnt = 5.
  - sat_event = 1 in both cases.
- Overflow: DEPTH = 4, A = {1,3,5}, B = {2,4,6} -> keys 1..4 written, overflow = 1, out_len = 4, done at cycle 6.
- Length clamp: DEPTH = 4, A = {1,2,3,4}, len_a = 5, len_b = 0 -> exactly 4 writes, no overflow.
- Reset and start rules:
  - reset low at cycle 2 of the basic merge -> IDLE next edge, no writes after it.
  - A restart then reproduces the full basic result.
  - A start pulse held during MERGE is ignored.
